// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- handshaked, registered execute-stage ALU.
//
// Accepts one request at a time over a valid/ready pair. Single-cycle
// operations register their result on the accept edge. Multiply and divide
// (optional) iterate one bit per cycle and present a double-width result:
// {result_hi, result} is the product, or result/result_hi hold the
// quotient/remainder.
//
// Optional feature macro: ALU_SEQ_MULDIV_EN
//   defined     -> codes 04..07 (mul/div) implemented, BUSY state present
//   not defined -> codes 04..07 reported as illegal, no mul/div datapath
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operation request
//   in_ready   out  block idle and able to accept a request
//   func       in   6-bit operation code
//   op_0       in   first operand / shift source
//   op_1       in   second operand; op_1[SHW-1:0] is the shift amount
//   out_valid  out  result available
//   out_ready  in   consumer takes the result
//   result     out  primary result
//   result_hi  out  product high half or remainder, 0 otherwise
//   ovf        out  signed add/sub overflow
//   div_zero   out  divide by zero
//   illegal    out  unsupported func
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] op_0,
  input  logic [WIDTH-1:0] op_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             ovf,
  output logic             div_zero,
  output logic             illegal
);

  // Function codes (the logic ops and shifts sit at 0x08/0x09 and 0x10..0x14;
  // 0x0A..0x0F and everything above 0x14 are unused).
  localparam logic [5:0] F_ADD  = 6'h00;
  localparam logic [5:0] F_ADDU = 6'h01;
  localparam logic [5:0] F_SUB  = 6'h02;
  localparam logic [5:0] F_SUBU = 6'h03;
`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [5:0] F_MUL  = 6'h04;
  localparam logic [5:0] F_MULU = 6'h05;
  localparam logic [5:0] F_DIV  = 6'h06;
  localparam logic [5:0] F_DIVU = 6'h07;
`endif
  localparam logic [5:0] F_AND  = 6'h08;
  localparam logic [5:0] F_OR   = 6'h09;
  localparam logic [5:0] F_XOR  = 6'h10;
  localparam logic [5:0] F_NOR  = 6'h11;
  localparam logic [5:0] F_SLL  = 6'h12;
  localparam logic [5:0] F_SRA  = 6'h13;
  localparam logic [5:0] F_SRL  = 6'h14;

`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_t;
`endif

  state_t state;
  state_t state_next;

  logic accept;
  assign accept = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live request inputs so the result
  // can be registered on the accept edge itself.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;

  assign sum   = op_0 + op_1;
  assign diff  = op_0 - op_1;
  assign shamt = op_1[SHW-1:0];

  logic [WIDTH-1:0] sc_result;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_ovf;
  logic             sc_div_zero;
  logic             sc_illegal;
  logic             sc_multi;    // request needs the iterative datapath

  always_comb begin
    sc_result   = '0;
    sc_hi       = '0;
    sc_ovf      = 1'b0;
    sc_div_zero = 1'b0;
    sc_illegal  = 1'b0;
    sc_multi    = 1'b0;
    case (func)
      F_ADD: begin
        sc_result = sum;
        // Overflow: operands share a sign that the sum does not.
        sc_ovf = (op_0[WIDTH-1] == op_1[WIDTH-1]) && (sum[WIDTH-1] != op_0[WIDTH-1]);
      end
      F_ADDU: sc_result = sum;
      F_SUB: begin
        sc_result = diff;
        // Overflow: operand signs differ and the difference flips sign.
        sc_ovf = (op_0[WIDTH-1] != op_1[WIDTH-1]) && (diff[WIDTH-1] != op_0[WIDTH-1]);
      end
      F_SUBU: sc_result = diff;
`ifdef ALU_SEQ_MULDIV_EN
      F_MUL, F_MULU: sc_multi = 1'b1;
      F_DIV, F_DIVU: begin
        // A zero divisor short-circuits: no iteration, fixed result pattern.
        if (op_1 == '0) begin
          sc_result   = '1;
          sc_hi       = op_0;
          sc_div_zero = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
`endif
      F_AND: sc_result = op_0 & op_1;
      F_OR:  sc_result = op_0 | op_1;
      F_XOR: sc_result = op_0 ^ op_1;
      F_NOR: sc_result = ~(op_0 | op_1);
      F_SLL: sc_result = op_0 << shamt;
      F_SRA: sc_result = $signed(op_0) >>> shamt;
      F_SRL: sc_result = op_0 >> shamt;
      default: sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  // -------------------------------------------------------------------------
  // Iterative multiply / divide. Both share one {acc_hi, acc_lo} register
  // pair and operate on magnitudes; signs are re-applied on the last step.
  //   multiply: acc_lo = multiplier (shifted out LSB first),
  //             acc_hi = running upper product, opa = multiplicand
  //   divide:   acc_lo = dividend shifting out / quotient shifting in,
  //             acc_hi = partial remainder, opa = divisor
  // -------------------------------------------------------------------------
  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);

  logic [SHW:0]     cnt;
  logic             is_div;
  logic             neg_lo;      // negate product / quotient at the end
  logic             neg_hi;      // negate remainder at the end
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             start_signed;
  logic             start_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign start_signed = (func == F_MUL) || (func == F_DIV);
  assign start_div    = (func == F_DIV) || (func == F_DIVU);
  assign a_neg        = start_signed && op_0[WIDTH-1];
  assign b_neg        = start_signed && op_1[WIDTH-1];
  // The most negative value maps onto itself, which is its correct
  // unsigned magnitude.
  assign a_mag        = a_neg ? -op_0 : op_0;
  assign b_mag        = b_neg ? -op_1 : op_1;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_trial;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opa : {WIDTH{1'b0}})};
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opa};
  // Only taken when div_shift >= opa, so the true difference fits WIDTH bits.
  assign div_trial = div_shift[WIDTH-1:0] - opa;

  always_comb begin
    if (is_div) begin
      step_hi = div_ge ? div_trial : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // The step taken while the counter reads 1 is the last one; its outcome
  // is sign-corrected and written straight into the output registers.
  logic last_step;
  assign last_step = (state == S_BUSY) && (cnt == (SHW+1)'(1));

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;

  assign prod_fix = neg_lo ? -{step_hi, step_lo} : {step_hi, step_lo};

  always_comb begin
    if (is_div) begin
      fin_lo = neg_lo ? -step_lo : step_lo;
      fin_hi = neg_hi ? -step_hi : step_hi;
    end else begin
      fin_lo = prod_fix[WIDTH-1:0];
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      opa    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (accept && sc_multi) begin
      cnt    <= CNT_LOAD;
      is_div <= start_div;
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= start_div && a_neg;   // remainder follows the dividend
      acc_hi <= '0;
      if (start_div) begin
        acc_lo <= a_mag;
        opa    <= b_mag;
      end else begin
        acc_lo <= b_mag;
        opa    <= a_mag;
      end
    end else if (state == S_BUSY) begin
      cnt    <= cnt - (SHW+1)'(1);
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
          state_next = sc_multi ? S_BUSY : S_DONE;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_BUSY: begin
        if (last_step) begin
          state_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Output registers: written only on a single-cycle accept or on the last
  // iteration, so they hold steady throughout DONE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !sc_multi) begin
      result    <= sc_result;
      result_hi <= sc_hi;
      ovf       <= sc_ovf;
      div_zero  <= sc_div_zero;
      illegal   <= sc_illegal;
    end
`ifdef ALU_SEQ_MULDIV_EN
    else if (last_step) begin
      result    <= fin_lo;
      result_hi <= fin_hi;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH = 32).
// Expected values in the vector table are worked out by hand. Latency is
// counted in clock cycles from the cycle the request is presented: a
// single-cycle op shows out_valid 1 cycle later, an iterative mul/div
// WIDTH+1 cycles later.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   func;
  logic [W-1:0] op_0;
  logic [W-1:0] op_1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         ovf;
  logic         div_zero;
  logic         illegal;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .op_0      (op_0),
    .op_1      (op_1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .ovf       (ovf),
    .div_zero  (div_zero),
    .illegal   (illegal)
  );

  int test_count = 0;
  int fail_count = 0;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic [2:0]   fl;   // {ovf, div_zero, illegal}
    int           lat;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
    test_count++;
    if (obsv !== expv) begin
      fail_count++;
      $display("FAIL %s: got %0h, expected %0h", tag, obsv, expv);
    end
  endtask

  task automatic add_vec(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic [W-1:0] h,
                         input logic [2:0] fl, input int lat);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.r = r; v.h = h; v.fl = fl; v.lat = lat;
    vq.push_back(v);
  endtask

  // Present a request, let it be accepted, and wait (bounded) for out_valid.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge clk);
    func     = f;
    op_0     = a;
    op_1     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    issue(v.f, v.a, v.b, lat);
    $display("[TB] #%0d func=%02h op_0=%08h op_1=%08h -> result=%08h result_hi=%08h ovf=%0b div_zero=%0b illegal=%0b lat=%0d",
             idx, v.f, v.a, v.b, result, result_hi, ovf, div_zero, illegal, lat);
    check($sformatf("v%0d_lat", idx), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d_result", idx), 64'(result), 64'(v.r));
    check($sformatf("v%0d_result_hi", idx), 64'(result_hi), 64'(v.h));
    check($sformatf("v%0d_flags", idx), 64'({ovf, div_zero, illegal}), 64'(v.fl));
    check($sformatf("v%0d_in_ready_done", idx), 64'(in_ready), 64'(0));
    release_op();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    func      = '0;
    op_0      = '0;
    op_1      = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_result_hi", 64'(result_hi), 64'(0));
    check("rst_flags", 64'({ovf, div_zero, illegal}), 64'(0));
    rst_n = 1'b1;

    // ---------------- directed vectors ----------------
    add_vec(6'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 3'b100, 1);
    add_vec(6'h01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h0, 3'b000, 1);
    add_vec(6'h02, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 3'b100, 1);
    add_vec(6'h03, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0, 3'b000, 1);
    add_vec(6'h02, 32'h00000005, 32'h00000003, 32'h00000002, 32'h0, 3'b000, 1);
    add_vec(6'h08, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 3'b000, 1);
    add_vec(6'h09, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 32'h0, 3'b000, 1);
    add_vec(6'h10, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 32'h0, 3'b000, 1);
    add_vec(6'h11, 32'h0F0F0F0F, 32'hF0F0F000, 32'h000000F0, 32'h0, 3'b000, 1);
    add_vec(6'h12, 32'h00000001, 32'h00000021, 32'h00000002, 32'h0, 3'b000, 1);
    add_vec(6'h13, 32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 3'b000, 1);
    add_vec(6'h14, 32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 3'b000, 1);
    add_vec(6'h12, 32'h00000003, 32'h0000001F, 32'h80000000, 32'h0, 3'b000, 1);
    add_vec(6'h13, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 32'h0, 3'b000, 1);
    add_vec(6'h0A, 32'h00001234, 32'h00005678, 32'h00000000, 32'h0, 3'b001, 1);
    add_vec(6'h3F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 3'b001, 1);
`ifdef ALU_SEQ_MULDIV_EN
    add_vec(6'h04, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 3'b000, W + 1);
    add_vec(6'h05, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 3'b000, W + 1);
    add_vec(6'h06, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 3'b000, W + 1);
    add_vec(6'h07, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 3'b010, 1);
    add_vec(6'h06, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 3'b000, W + 1);
    add_vec(6'h07, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 3'b000, W + 1);
    add_vec(6'h06, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 3'b000, W + 1);
    add_vec(6'h06, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 3'b010, 1);
    add_vec(6'h04, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 3'b000, W + 1);
`else
    add_vec(6'h04, 32'hFFFFFFFE, 32'h00000003, 32'h00000000, 32'h0, 3'b001, 1);
    add_vec(6'h05, 32'h00000002, 32'h00000003, 32'h00000000, 32'h0, 3'b001, 1);
    add_vec(6'h06, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h0, 3'b001, 1);
    add_vec(6'h07, 32'h00000007, 32'h00000000, 32'h00000000, 32'h0, 3'b001, 1);
`endif
    foreach (vq[i]) run_vec(i, vq[i]);

    // ---------------- hold in DONE, requests ignored ----------------
    issue(6'h00, 32'h7FFFFFFF, 32'h00000001, lat);
    check("hold_lat", 64'(lat), 64'(1));
    func     = 6'h01;
    op_0     = 32'h00000001;
    op_1     = 32'h00000002;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      $display("[TB] hold cycle %0d: out_valid=%0b in_ready=%0b result=%08h ovf=%0b",
               k, out_valid, in_ready, result, ovf);
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_result", 64'(result), 64'(32'h80000000));
      check("hold_ovf", 64'(ovf), 64'(1));
    end
    in_valid = 1'b0;
    release_op();
    @(negedge clk);
    check("post_hold_out_valid", 64'(out_valid), 64'(0));
    check("post_hold_in_ready", 64'(in_ready), 64'(1));

`ifdef ALU_SEQ_MULDIV_EN
    // ---------------- reset mid-BUSY ----------------
    // Previous result (0x80000000 / ovf) is nonzero, so clearing is visible.
    func     = 6'h04;
    op_0     = 32'hFFFFFFFE;
    op_1     = 32'h00000003;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_in_ready", 64'(in_ready), 64'(0));
    check("busy_out_valid", 64'(out_valid), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("rstb_result", 64'(result), 64'(0));
    check("rstb_flags", 64'({ovf, div_zero, illegal}), 64'(0));
    @(negedge clk);
    check("rstb_in_ready", 64'(in_ready), 64'(1));
    rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    $display("[TB] reset mid-BUSY: out_valid pulses afterwards=%0d", pulses);
    check("rstb_no_pulse", 64'(pulses), 64'(0));
`endif

    // ---------------- reset in DONE ----------------
    issue(6'h00, 32'h7FFFFFFF, 32'h00000001, lat);
    check("rstd_pre_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rstd_out_valid", 64'(out_valid), 64'(0));
    check("rstd_in_ready", 64'(in_ready), 64'(1));
    check("rstd_result", 64'(result), 64'(0));
    check("rstd_result_hi", 64'(result_hi), 64'(0));
    check("rstd_flags", 64'({ovf, div_zero, illegal}), 64'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    $display("[TB] reset in DONE: out_valid pulses afterwards=%0d", pulses);
    check("rstd_no_pulse", 64'(pulses), 64'(0));

    // ---------------- recovery after reset ----------------
    begin
      vec_t v;
      v.f = 6'h01; v.a = 32'h2; v.b = 32'h3; v.r = 32'h5; v.h = 32'h0; v.fl = 3'b000; v.lat = 1;
      run_vec(99, v);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
